// File: rtl/average_store_reader.sv
// Running-average table: raw FP16 write port, combinational write-first lookup, and burst read-out stream.
// Latency: lookup 0 cycles; first read beat 1 edge after request accept, then 1 beat/cycle.
// Backpressure: rd_ready low freezes the held beat snapshot; request accepted only when idle. Optional clear: AVG_STORE_CLEAR_EN.
module average_store_reader #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef AVG_STORE_CLEAR_EN
    input  logic             clr,
`endif
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [15:0]      wr_data,
    input  logic [IDX_W-1:0] lk_idx,
    output logic [15:0]      lk_data,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [IDX_W-1:0] rd_req_start,
    input  logic [IDX_W:0]   rd_req_len,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [15:0]      rd_data,
    output logic [IDX_W-1:0] rd_idx,
    output logic             rd_last,
    output logic             busy
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   ONE_L   = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] PTR_INC = IDX_W'(1);

    logic clr_i;
`ifdef AVG_STORE_CLEAR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      mem_d [DEPTH];
    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   rem_q, rem_d;
    logic             rd_valid_q, rd_valid_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             rd_last_q, rd_last_d;

    logic             load_en;
    logic [IDX_W-1:0] load_ptr;
    logic [IDX_W:0]   load_rem;
    logic [IDX_W:0]   len_eff;
    logic [15:0]      load_src;

    // Clear beats any same-edge write and suppresses the bypass path.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    assign lk_data = clr_i ? 16'h0000 :
                     (wr_en && (wr_idx == lk_idx)) ? wr_data : mem_q[lk_idx];

    assign len_eff = (rd_req_len > DEPTH_L) ? DEPTH_L : rd_req_len;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_idx_d   = rd_idx_q;
        rd_last_d  = rd_last_q;
        load_en    = 1'b0;
        load_ptr   = ptr_q;
        load_rem   = rem_q;
        load_src   = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (rd_req_valid && (len_eff != '0)) begin
                    load_en  = 1'b1;
                    load_ptr = rd_req_start;
                    load_rem = len_eff - ONE_L;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (rd_valid_q && rd_ready) begin
                    if (rem_q != '0) begin
                        load_en  = 1'b1;
                        load_ptr = ptr_q;
                        load_rem = rem_q - ONE_L;
                    end else begin
                        rd_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rd_valid_d = 1'b0;
            end
        endcase

        // Snapshot taken at the load edge; later writes to this index do not touch it.
        if (load_en) begin
            if (clr_i) begin
                load_src = 16'h0000;
            end else if (wr_en && (wr_idx == load_ptr)) begin
                load_src = wr_data;
            end else begin
                load_src = mem_q[load_ptr];
            end
            rd_data_d  = load_src;
            rd_idx_d   = load_ptr;
            rd_last_d  = (load_rem == '0);
            rd_valid_d = 1'b1;
            rem_d      = load_rem;
            ptr_d      = load_ptr + PTR_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_idx_q   <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_idx_q   <= rd_idx_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign rd_req_ready = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_STREAM);
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_idx       = rd_idx_q;
    assign rd_last      = rd_last_q;

endmodule

// File: tb/tb_average_store_reader.sv
// Directed bench for average_store_reader (DEPTH=16) with an expected-beat queue.
module tb_average_store_reader;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [15:0]      wr_data;
    logic [IDX_W-1:0] lk_idx;
    logic [15:0]      lk_data;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [IDX_W-1:0] rd_req_start;
    logic [IDX_W:0]   rd_req_len;
    logic             rd_valid;
    logic             rd_ready;
    logic [15:0]      rd_data;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_last;
    logic             busy;

    typedef struct packed {
        logic [15:0]      data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] model [DEPTH];
    int          checks = 0;
    int          errors = 0;

    average_store_reader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef AVG_STORE_CLEAR_EN
        .clr          (clr),
`endif
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .lk_idx       (lk_idx),
        .lk_data      (lk_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_start (rd_req_start),
        .rd_req_len   (rd_req_len),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_idx       (rd_idx),
        .rd_last      (rd_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Beats handshake at the next posedge when valid&&ready at the negedge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {11'd0, rd_data, rd_idx, rd_last}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {11'd0, rd_data, rd_idx, rd_last}, {11'd0, e.data, e.idx, e.last});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int start, input int n, input bit last_at_end);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.idx  = IDX_W'((start + i) % DEPTH);
            b.data = model[(start + i) % DEPTH];
            b.last = last_at_end && (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wr(input int idx, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(idx);
        wr_data = d;
        model[idx] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic req(input int start, input int len, input bit expect_beat);
        rd_req_valid = 1'b1;
        rd_req_start = IDX_W'(start);
        rd_req_len   = (IDX_W+1)'(len);
        chk("req_ready_before", 32'(rd_req_ready), 32'd1);
        tick();
        rd_req_valid = 1'b0;
        chk("first_valid_latency", 32'(rd_valid), 32'(expect_beat));
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_q.size() == 0 && !rd_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req_ready", 32'(rd_req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; lk_idx = '0;
        rd_req_valid = 1'b0; rd_req_start = '0; rd_req_len = '0; rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(rd_req_ready), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_idx", 32'(rd_idx), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);

        // Plain burst of zeros.
        push_range(0, 4, 1'b1);
        req(0, 4, 1'b1);
        drain();

        // Same-cycle write bypass on lookup, then stored lookup.
        wr_en = 1'b1; wr_idx = 4'd5; wr_data = 16'h3C00; lk_idx = 4'd5;
        model[5] = 16'h3C00;
        #2;
        chk("lk_bypass", 32'(lk_data), 32'h3C00);
        tick();
        wr_en = 1'b0;
        wr(6, 16'h4000);
        lk_idx = 4'd6;
        #1;
        chk("lk_stored", 32'(lk_data), 32'h4000);
        push_range(5, 2, 1'b1);
        req(5, 2, 1'b1);
        drain();

        // Wrap-around burst.
        wr(15, 16'h3800);
        wr(0, 16'h3400);
        push_range(15, 3, 1'b1);
        req(15, 3, 1'b1);
        drain();

        // Stall with writes to the held index and the next index.
        rd_ready = 1'b0;
        push_range(2, 1, 1'b0);
        req(2, 3, 1'b1);
        wr(2, 16'h4200);
        chk("stall_hold_data", 32'(rd_data), 32'h0000);
        wr(3, 16'h4400);
        chk("stall_hold_idx", 32'(rd_idx), 32'd2);
        tick();
        chk("stall_hold_data2", 32'(rd_data), 32'h0000);
        chk("stall_valid", 32'(rd_valid), 32'd1);
        push_range(3, 2, 1'b1);
        rd_ready = 1'b1;
        drain();

        // Zero-length request, then over-long request clamped to DEPTH.
        req(7, 0, 1'b0);
        chk("len0_req_ready", 32'(rd_req_ready), 32'd1);
        tick();
        chk("len0_no_valid", 32'(rd_valid), 32'd0);
        push_range(4, 16, 1'b1);
        req(4, 20, 1'b1);
        drain();

        // Reset mid-burst drops remaining beats and clears the table.
        push_range(0, 2, 1'b0);
        req(0, 8, 1'b1);
        tick();
        tick();
        rd_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rd_ready = 1'b1;
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 16'h0000;
            lk_idx = IDX_W'(i);
            #1;
            chk("rst_table", 32'(lk_data), 32'h0000);
        end
        tick();
        chk("post_rst_no_beat", 32'(rd_valid), 32'd0);

`ifdef AVG_STORE_CLEAR_EN
        wr(1, 16'h1234);
        clr = 1'b1; wr_en = 1'b1; wr_idx = 4'd1; wr_data = 16'h5000; lk_idx = 4'd1;
        #1;
        chk("clr_bypass_suppressed", 32'(lk_data), 32'h0000);
        tick();
        clr = 1'b0; wr_en = 1'b0;
        model[1] = 16'h0000;
        #1;
        chk("clr_wins", 32'(lk_data), 32'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
